// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: items shared by the sequential binary-to-BCD converter.
//   state_t   - converter FSM states (IDLE, SHIFT, COMMIT), 2-bit encoding
//   cnt_width - width of the iteration counter for a given input width
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // The counter has to hold BIN_W itself, hence clog2(BIN_W+1).
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell.
//   i_digit - BCD digit before the shift
//   o_digit - digit + 3 when digit >= 5, otherwise unchanged (4-bit wrap)
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock, start/busy/done handshake.
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   start    - request a conversion, honoured only while idle
//   binary   - value to convert, captured with an accepted start
//   busy     - conversion in progress
//   done     - one-cycle pulse; bcd/negative/overflow just updated
//   bcd      - packed BCD digits, ones digit in [3:0]
//   negative - input was negative (SIGNED=1 only)
//   overflow - magnitude above 10^DIGITS-1; bcd holds value mod 10^DIGITS
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int DW    = 4 * DIGITS;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_W-1:0]   r_bin;
    logic [DW-1:0]      r_dig;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_ovf_sticky;
    logic [DW-1:0]      r_bcd;
    logic               r_neg;
    logic               r_ovf;
    logic               r_done;

    logic               w_in_neg;
    logic [BIN_W-1:0]   w_mag;
    logic [DW-1:0]      w_adj;

    // Most-negative input negates to itself, which read unsigned is
    // exactly 2^(BIN_W-1), the correct magnitude.
    always_comb begin
        w_in_neg = (SIGNED != 0) && binary[BIN_W-1];
        w_mag    = binary;
        if (w_in_neg) begin
            w_mag = ~binary + BIN_W'(1);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_dig[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin        <= '0;
            r_dig        <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_bcd        <= '0;
            r_neg        <= 1'b0;
            r_ovf        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin        <= w_mag;
                        r_sign       <= w_in_neg;
                        r_dig        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    // Adjusted digits and bin shift left as one register;
                    // the bit leaving the top digit is lost, so flag it.
                    r_dig <= {w_adj[DW-2:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_adj[DW-1]) begin
                        r_ovf_sticky <= 1'b1;
                    end
                end
                COMMIT: begin
                    r_bcd  <= r_dig;
                    r_neg  <= r_sign;
                    r_ovf  <= r_ovf_sticky;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign negative = r_neg;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq against a
// decimal-arithmetic reference model, for three parameter sets:
//   sel 0: defaults (13-bit unsigned, 4 digits)
//   sel 1: 8-bit signed, 3 digits
//   sel 2: 13-bit unsigned, 3 digits (overflow reachable)
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [12:0] bi0 = '0;
    logic [7:0]  bi1 = '0;
    logic [12:0] bi2 = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] bcd0;
    logic [11:0] bcd1, bcd2;
    logic        neg0, neg1, neg2;
    logic        ovf0, ovf1, ovf2;

    int n_checks = 0;
    int n_errors = 0;

    bin2bcd_seq dut0 (
        .clk(clk), .rst(rst), .start(st0), .binary(bi0), .busy(busy0),
        .done(done0), .bcd(bcd0), .negative(neg0), .overflow(ovf0)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .binary(bi1), .busy(busy1),
        .done(done1), .bcd(bcd1), .negative(neg1), .overflow(ovf1)
    );

    bin2bcd_seq #(.BIN_W(13), .DIGITS(3), .SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .binary(bi2), .busy(busy2),
        .done(done2), .bcd(bcd2), .negative(neg2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the decimal value.
    function automatic void ref_model(input longint raw, input int bw, input int d,
                                      input int sgn, output logic [63:0] exp_bcd,
                                      output logic exp_neg, output logic exp_ovf);
        longint v;
        longint lim;
        v = raw % (longint'(1) << bw);
        exp_neg = 1'b0;
        if (sgn != 0 && v >= (longint'(1) << (bw - 1))) begin
            v = (longint'(1) << bw) - v;
            exp_neg = 1'b1;
        end
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        exp_ovf = (v >= lim);
        v = v % lim;
        exp_bcd = '0;
        for (int i = 0; i < d; i++) begin
            exp_bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    task automatic set_start(input int sel, input logic s, input logic [12:0] v);
        case (sel)
            0:       begin st0 = s; bi0 = v; end
            1:       begin st1 = s; bi1 = v[7:0]; end
            default: begin st2 = s; bi2 = v; end
        endcase
    endtask

    function automatic logic obs_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic obs_done(input int sel);
        return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic [63:0] obs_bcd(input int sel);
        return (sel == 0) ? 64'(bcd0) : (sel == 1) ? 64'(bcd1) : 64'(bcd2);
    endfunction

    function automatic logic obs_neg(input int sel);
        return (sel == 0) ? neg0 : (sel == 1) ? neg1 : neg2;
    endfunction

    function automatic logic obs_ovf(input int sel);
        return (sel == 0) ? ovf0 : (sel == 1) ? ovf1 : ovf2;
    endfunction

    // Entered at a negedge; returns at the negedge where done is seen.
    // glitch_cyc >= 0 pulses start with glitch_val while busy.
    task automatic convert(input int sel, input logic [12:0] val,
                           input int glitch_cyc, input logic [12:0] glitch_val);
        int bw;
        int d;
        int cyc;
        int busy_cnt;
        logic got;
        logic [63:0] e_bcd;
        logic e_neg, e_ovf;
        bw = (sel == 1) ? 8 : 13;
        d  = (sel == 0) ? 4 : 3;
        ref_model(longint'(val), bw, d, (sel == 1) ? 1 : 0, e_bcd, e_neg, e_ovf);
        set_start(sel, 1'b1, val);
        @(posedge clk);
        @(negedge clk);
        set_start(sel, 1'b0, 13'($urandom));
        cyc = 0;
        busy_cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (obs_busy(sel)) busy_cnt++;
            if (glitch_cyc >= 0 && k == glitch_cyc) set_start(sel, 1'b1, glitch_val);
            else if (glitch_cyc >= 0 && k == glitch_cyc + 1) set_start(sel, 1'b0, 13'($urandom));
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (obs_done(sel)) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'(1));
        check("latency", 64'(cyc), 64'(bw + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(bw + 1));
        check("busy_at_done", 64'(obs_busy(sel)), 64'(0));
        check("bcd", obs_bcd(sel), e_bcd);
        check("negative", 64'(obs_neg(sel)), 64'(e_neg));
        check("overflow", 64'(obs_ovf(sel)), 64'(e_ovf));
    endtask

    initial begin
        int dones;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_done", 64'(done0), 64'(0));
        check("rst_bcd", 64'(bcd0), 64'(0));
        check("rst_neg", 64'(neg1), 64'(0));
        check("rst_ovf", 64'(ovf2), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Default set: directed, then back-to-back with no idle gap.
        convert(0, 13'd4999, -1, '0);
        convert(0, 13'd8191, -1, '0);
        convert(0, 13'd0, -1, '0);
        @(negedge clk);
        check("done_one_cycle", 64'(done0), 64'(0));

        // Signed 8-bit corner values.
        convert(1, 13'h080, -1, '0);
        convert(1, 13'h0FF, -1, '0);
        convert(1, 13'h07F, -1, '0);
        convert(1, 13'h000, -1, '0);

        // 3-digit overflow boundary.
        convert(2, 13'd1000, -1, '0);
        convert(2, 13'd999, -1, '0);

        // Randomized conversions on every parameter set.
        for (int i = 0; i < 12; i++) begin
            convert(0, 13'($urandom), -1, '0);
            convert(1, 13'($urandom_range(255, 0)), -1, '0);
            convert(2, 13'($urandom), -1, '0);
        end

        // start while busy is ignored; exactly one done pulse follows.
        convert(0, 13'd1234, 5, 13'd5678);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) dones++;
        end
        check("single_done", 64'(dones), 64'(0));
        check("bcd_hold", 64'(bcd0), 64'h1234);

        // Asynchronous reset mid-conversion.
        set_start(0, 1'b1, 13'd4321);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy0), 64'(0));
        check("arst_bcd", 64'(bcd0), 64'(0));
        check("arst_neg", 64'(neg0), 64'(0));
        check("arst_ovf", 64'(ovf0), 64'(0));
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0) dones++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done0) dones++;
        end
        check("arst_no_done", 64'(dones), 64'(0));
        convert(0, 13'd4321, -1, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
